// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
//   HEX_SEG    : active-high segment codes (g..a) for hex digits 0..F
//   SEG_BLANK  : active-high "nothing lit" pattern including dp
//   tick_width : width of the per-slot tick counter for a given slot length
package seg7_pkg;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic int tick_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble + dp to 8-bit segment pattern (bit7 = dp, bits6:0 = g..a).
//   nibble : hex value to show
//   dp     : decimal point request
//   blank  : suppress the digit glyph (dp still honoured)
//   seg    : pattern in board polarity (inverted when ACTIVE_LOW != 0)
module seg7_hex_decoder
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] seg_hi;

  always_comb begin
    seg_hi = SEG_BLANK;
    if (!blank) seg_hi[6:0] = HEX_SEG[nibble];
    seg_hi[7] = dp;
    seg = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Parametrised multiplexed seven-segment scan driver.
//   Clk, Rst      : clock, synchronous active-high reset
//   DigitData     : hex nibbles, nibble i -> digit i
//   DpIn          : decimal point request per digit
//   LoadValid/LoadReady : double-buffered load handshake (commit at frame boundary)
//   LzSuppress    : leading-zero suppression, sampled live
//   Brightness    : PWM duty (tick[3:0] <= Brightness), sampled live
//   SevenSegment  : bit7 = dp, bits6:0 = g..a, registered
//   Enable        : digit selects, registered
//   FrameStart    : one-cycle pulse with the first output cycle of digit 0
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int REFRESH_DIV    = 12000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int EN_ACTIVE_LOW  = 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] DigitData,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic                    LoadValid,
  output logic                    LoadReady,
  input  logic                    LzSuppress,
  input  logic [3:0]              Brightness,
  output logic [7:0]              SevenSegment,
  output logic [NUM_DIGITS-1:0]   Enable,
  output logic                    FrameStart
);

  localparam int TICK_W = tick_width(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0]     TICK_LAST  = TICK_W'(REFRESH_DIV - 1);
  localparam logic [TICK_W-1:0]     TICK_BLANK = TICK_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] EN_OFF     = (EN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

  logic [TICK_W-1:0]     tick;
  logic [IDX_W-1:0]      idx;
  logic [4*NUM_DIGITS-1:0] shadow_data, active_data;
  logic [NUM_DIGITS-1:0] shadow_dp, active_dp;
  logic                  pending;

  logic tick_wrap, frame_end, load_accept;

  assign tick_wrap   = (tick == TICK_LAST);
  assign frame_end   = tick_wrap && (idx == IDX_LAST);
  assign LoadReady   = ~pending;
  assign load_accept = LoadValid && ~pending;

  // Scan counters
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick_wrap) begin
      tick <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Shadow/active double buffer. Accept and commit are mutually exclusive
  // because an accept needs pending=0 and a commit needs pending=1.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      pending     <= 1'b0;
    end else if (load_accept) begin
      shadow_data <= DigitData;
      shadow_dp   <= DpIn;
      pending     <= 1'b1;
    end else if (frame_end && pending) begin
      active_data <= shadow_data;
      active_dp   <= shadow_dp;
      pending     <= 1'b0;
    end
  end

  // zero_tail[i]: nibbles i..NUM_DIGITS-1 of the active value are all zero
  logic [NUM_DIGITS-1:0] zero_tail;

  always_comb begin
    zero_tail = '0;
    zero_tail[NUM_DIGITS-1] = (active_data[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_tail[i] = zero_tail[i+1] && (active_data[4*i +: 4] == 4'h0);
    end
  end

  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_lz;
  logic                  cur_drive;
  logic [NUM_DIGITS-1:0] en_onehot;
  logic [7:0]            dec_seg;

  // A suppressed digit with its dp set still drives, glyph blanked.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = active_data[4*i +: 4];
        cur_dp     = active_dp[i];
        cur_lz     = (i > 0) && LzSuppress && zero_tail[i];
      end
    end
    cur_drive = (tick >= TICK_BLANK) && (tick[3:0] <= Brightness) && !(cur_lz && !cur_dp);
    en_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      en_onehot[i] = cur_drive && (idx == IDX_W'(i));
    end
  end

  seg7_hex_decoder #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .blank  (cur_lz),
    .seg    (dec_seg)
  );

  // Registered outputs: one cycle behind the counters
  always_ff @(posedge Clk) begin
    if (Rst) begin
      SevenSegment <= SEG_OFF;
      Enable       <= EN_OFF;
      FrameStart   <= 1'b0;
    end else begin
      SevenSegment <= cur_drive ? dec_seg : SEG_OFF;
      Enable       <= (EN_ACTIVE_LOW != 0) ? ~en_onehot : en_onehot;
      FrameStart   <= (tick == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        Rst;
  logic [11:0] DigitData;
  logic [2:0]  DpIn;
  logic        LoadValid;
  logic        LoadReady;
  logic        LzSuppress;
  logic [3:0]  Brightness;
  logic [7:0]  SevenSegment;
  logic [2:0]  Enable;
  logic        FrameStart;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS     (3),
    .REFRESH_DIV    (32),
    .BLANK_CYCLES   (4),
    .SEG_ACTIVE_LOW (1),
    .EN_ACTIVE_LOW  (1)
  ) dut (
    .Clk          (clk),
    .Rst          (Rst),
    .DigitData    (DigitData),
    .DpIn         (DpIn),
    .LoadValid    (LoadValid),
    .LoadReady    (LoadReady),
    .LzSuppress   (LzSuppress),
    .Brightness   (Brightness),
    .SevenSegment (SevenSegment),
    .Enable       (Enable),
    .FrameStart   (FrameStart)
  );

  typedef struct packed {
    logic [11:0] data;
    logic [2:0]  dp;
    logic        lz;
    logic [3:0]  br;
    logic [23:0] segs;   // {slot2, slot1, slot0}
    logic [2:0]  drv;    // slots expected to drive at all
    logic [5:0]  first;
    logic [5:0]  last;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs [8];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_seg   [3];
  int         m_first [3];
  int         m_last  [3];
  int         m_cnt   [3];
  int         m_bad;

  function automatic vec_t mk(input logic [11:0] d, input logic [2:0] p, input logic lz,
                              input logic [3:0] br, input logic [23:0] segs,
                              input logic [2:0] drv, input int f, input int l, input int c);
    vec_t v;
    v.data = d; v.dp = p; v.lz = lz; v.br = br; v.segs = segs; v.drv = drv;
    v.first = 6'(f); v.last = 6'(l); v.cnt = 6'(c);
    return v;
  endfunction

  function automatic logic [7:0] old_seg(input int s);
    case (s)
      0:       return 8'h92;
      1:       return 8'h08;
      default: return 8'hF9;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge where FrameStart is seen; samples 96 output cycles
  // (output index k <-> slot k/32, tick k%32) and leaves on the next frame's first cycle.
  task automatic capture_frame();
    logic [2:0] act;
    int s, t;
    for (int j = 0; j < 3; j++) begin
      m_seg[j] = 8'hFF; m_first[j] = 0; m_last[j] = 0; m_cnt[j] = 0;
    end
    m_bad = 0;
    for (int k = 0; k < 96; k++) begin
      s = k / 32;
      t = k % 32;
      act = ~Enable;
      if (act == 3'b000) begin
        if (SevenSegment != 8'hFF) m_bad++;
      end else if (act != (3'b001 << s)) begin
        m_bad++;
      end else begin
        if (m_cnt[s] == 0) begin
          m_first[s] = t;
          m_seg[s]   = SevenSegment;
        end else if (SevenSegment != m_seg[s]) begin
          m_bad++;
        end
        m_last[s] = t;
        m_cnt[s]++;
      end
      if (k != 0 && FrameStart) m_bad++;
      @(negedge clk);
    end
  endtask

  task automatic cmp_frame(input string name, input vec_t v);
    logic [7:0] es;
    int ef, el, ec;
    for (int s = 0; s < 3; s++) begin
      if (v.drv[s]) begin
        es = v.segs[8*s +: 8]; ef = v.first; el = v.last; ec = v.cnt;
      end else begin
        es = 8'hFF; ef = 0; el = 0; ec = 0;
      end
      chk($sformatf("%s_seg%0d", name, s),   m_seg[s],   es);
      chk($sformatf("%s_first%0d", name, s), m_first[s], ef);
      chk($sformatf("%s_last%0d", name, s),  m_last[s],  el);
      chk($sformatf("%s_cnt%0d", name, s),   m_cnt[s],   ec);
    end
    chk($sformatf("%s_glitch", name), m_bad, 0);
    chk($sformatf("%s_period", name), FrameStart, 1);
  endtask

  task automatic do_load(input logic [11:0] d, input logic [2:0] p);
    int n = 0;
    while (!LoadReady && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", LoadReady, 1);
    DigitData = d;
    DpIn      = p;
    LoadValid = 1'b1;
    @(negedge clk);
    LoadValid = 1'b0;
    chk("ready_drop", LoadReady, 0);
  endtask

  task automatic wait_commit();
    int n = 0;
    while (!LoadReady && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("commit_ready", LoadReady, 1);
    @(negedge clk);
    chk("commit_fs", FrameStart, 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_en"},    Enable,       3'b111);
    chk({name, "_seg"},   SevenSegment, 8'hFF);
    chk({name, "_ready"}, LoadReady,    1);
    chk({name, "_fs"},    FrameStart,   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, old_bad;
    logic [2:0] act;

    vecs[0] = mk(12'h1A5, 3'b010, 1'b0, 4'd15, {8'hF9, 8'h08, 8'h92}, 3'b111, 4, 31, 28);
    vecs[1] = mk(12'h005, 3'b000, 1'b1, 4'd15, {8'hFF, 8'hFF, 8'h92}, 3'b001, 4, 31, 28);
    vecs[2] = mk(12'h000, 3'b000, 1'b1, 4'd15, {8'hFF, 8'hFF, 8'hC0}, 3'b001, 4, 31, 28);
    vecs[3] = mk(12'h005, 3'b100, 1'b1, 4'd15, {8'h7F, 8'hFF, 8'h92}, 3'b101, 4, 31, 28);
    vecs[4] = mk(12'h0A0, 3'b000, 1'b1, 4'd15, {8'hFF, 8'h88, 8'hC0}, 3'b011, 4, 31, 28);
    vecs[5] = mk(12'h1A5, 3'b010, 1'b0, 4'd7,  {8'hF9, 8'h08, 8'h92}, 3'b111, 4, 23, 12);
    vecs[6] = mk(12'h1A5, 3'b010, 1'b0, 4'd3,  {8'hF9, 8'h08, 8'h92}, 3'b111, 16, 19, 4);
    vecs[7] = mk(12'h1A5, 3'b010, 1'b0, 4'd0,  {8'hF9, 8'h08, 8'h92}, 3'b111, 16, 16, 1);

    Rst = 1'b1; DigitData = '0; DpIn = '0; LoadValid = 1'b0;
    LzSuppress = 1'b0; Brightness = 4'd15;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    Rst = 1'b0;
    chk("por_fs_release", FrameStart, 0);
    @(negedge clk);
    chk("por_fs_first", FrameStart, 1);
    capture_frame();
    cmp_frame("por_zero", mk(12'h000, 3'b000, 1'b0, 4'd15, {8'hC0, 8'hC0, 8'hC0}, 3'b111, 4, 31, 28));

    // Reset during operation, held two cycles
    repeat (50) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst1");
    @(negedge clk);
    chk_reset_outputs("rst2");
    Rst = 1'b0;
    @(negedge clk);
    chk("rst_fs_first", FrameStart, 1);

    for (int i = 0; i < 8; i++) begin
      Brightness = vecs[i].br;
      LzSuppress = vecs[i].lz;
      do_load(vecs[i].data, vecs[i].dp);
      wait_commit();
      capture_frame();
      cmp_frame($sformatf("vec%0d", i), vecs[i]);
    end

    // Handshake with LoadValid held high; 1A5 is on display, k=0 now.
    Brightness = 4'd15;
    LzSuppress = 1'b0;
    repeat (10) @(negedge clk);
    k = 10;
    DigitData = 12'h321; DpIn = 3'b000; LoadValid = 1'b1;
    @(negedge clk);
    k = 11;
    chk("hs_accept", LoadReady, 0);
    DigitData = 12'h777;
    old_bad = 0;
    while (!LoadReady && k < 300) begin
      act = ~Enable;
      if (act != 3'b000 && SevenSegment != old_seg((k / 32) % 3)) old_bad++;
      @(negedge clk);
      k++;
    end
    chk("hs_rise_k", k, 95);
    chk("hs_old_frame", old_bad, 0);
    @(negedge clk);
    chk("hs_fs", FrameStart, 1);
    chk("hs_second_accept", LoadReady, 0);
    LoadValid = 1'b0;
    capture_frame();
    cmp_frame("hs321", mk(12'h321, 3'b000, 1'b0, 4'd15, {8'hB0, 8'hA4, 8'hF9}, 3'b111, 4, 31, 28));
    capture_frame();
    cmp_frame("hs777", mk(12'h777, 3'b000, 1'b0, 4'd15, {8'hF8, 8'hF8, 8'hF8}, 3'b111, 4, 31, 28));

    // Reset mid slot1 with a load pending
    DigitData = 12'h1A5; DpIn = 3'b010; LoadValid = 1'b1;
    @(negedge clk);
    LoadValid = 1'b0;
    chk("mid_pending", LoadReady, 0);
    repeat (39) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    Rst = 1'b0;
    @(negedge clk);
    chk("mid_fs_first", FrameStart, 1);
    capture_frame();
    cmp_frame("mid_zero_a", mk(12'h000, 3'b000, 1'b0, 4'd15, {8'hC0, 8'hC0, 8'hC0}, 3'b111, 4, 31, 28));
    capture_frame();
    cmp_frame("mid_zero_b", mk(12'h000, 3'b000, 1'b0, 4'd15, {8'hC0, 8'hC0, 8'hC0}, 3'b111, 4, 31, 28));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
